johnson_phase_decoder: RTL and testbench

- Downstream consumer of the 4-bit Johnson counter's q bus.
- Registers the incoming Johnson code and decodes it to a phase index and a one-hot phase vector.
- Checks every sample for illegal codes and out-of-sequence steps.
- Runs a lock state machine so downstream timing logic only uses phases while the counter is stepping correctly.

---
 rtl/johnson_pkg.sv | 34 +++
 rtl/johnson_decode.sv | 18 +
 rtl/johnson_phase_decoder.sv | 140 ++++++++++++++
 tb/tb_johnson_phase_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared widths, lock states and Johnson code helpers
package johnson_pkg;

  localparam int JC_N = 4;
  localparam int NPH  = 2 * JC_N;
  localparam int IW   = $clog2(NPH);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // A Johnson code is a thermometer: at most one boundary between ones and zeros.
  function automatic logic jc_legal(input logic [JC_N-1:0] code);
    int unsigned trans;
    trans = 0;
    for (int i = 0; i < JC_N - 1; i++) begin
      if (code[i] != code[i+1]) trans++;
    end
    return (trans <= 1);
  endfunction

  function automatic logic [IW-1:0] jc_index(input logic [JC_N-1:0] code);
    int unsigned p;
    int unsigned r;
    p = 0;
    for (int i = 0; i < JC_N; i++) begin
      if (code[i]) p++;
    end
    r = code[JC_N-1] ? (NPH - p) : p;
    return r[IW-1:0];
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// rtl/johnson_decode.sv - combinational Johnson code to phase index / one-hot decode
module johnson_decode
  import johnson_pkg::*;
(
  input  logic [JC_N-1:0] jc_s,
  output logic            legal,
  output logic [IW-1:0]   idx,
  output logic [NPH-1:0]  phase
);

  always_comb begin
    legal = jc_legal(jc_s);
    idx   = jc_index(jc_s);
    phase = '0;
    if (legal) phase[idx] = 1'b1;
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// rtl/johnson_phase_decoder.sv - registered Johnson phase decode with sequence check and lock FSM
module johnson_phase_decoder
  import johnson_pkg::*;
#(
  parameter int N         = JC_N,
  parameter int LOCK_CNT  = 4,
  parameter int STALL_MAX = 15,
  parameter int ERR_W     = 8
) (
  input  logic                     clk,
  input  logic                     r,
  input  logic [N-1:0]             jc,
  output logic [2*N-1:0]           phase,
  output logic [$clog2(2*N)-1:0]   idx,
  output logic                     legal,
  output logic                     locked,
  output logic                     step_err,
  output logic [ERR_W-1:0]         err_cnt
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int HOLD_W = $clog2(STALL_MAX + 2);

  logic [N-1:0]       jc_s_q, jc_s_d;
  logic               vld_q, vld_d;
  logic               seed_q, seed_d;
  lock_state_e        state_q, state_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [NPH-1:0]     phase_q, phase_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               legal_q, legal_d;
  logic               step_err_q, step_err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic               dec_legal;
  logic [IW-1:0]      dec_idx;
  logic [NPH-1:0]     dec_phase;
  logic [IW-1:0]      nxt_idx;
  logic               is_succ, is_hold, stall;

  johnson_decode u_decode (
    .jc_s  (jc_s_q),
    .legal (dec_legal),
    .idx   (dec_idx),
    .phase (dec_phase)
  );

  always_comb begin
    jc_s_d     = jc;
    vld_d      = 1'b1;
    seed_d     = seed_q;
    state_d    = state_q;
    run_d      = run_q;
    hold_d     = hold_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    legal_d    = legal_q;
    step_err_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    stall      = 1'b0;
    nxt_idx    = (idx_q == IW'(NPH - 1)) ? '0 : idx_q + 1'b1;
    is_succ    = dec_legal && (dec_idx == nxt_idx);
    is_hold    = dec_legal && (dec_idx == idx_q);

    // vld_q keeps the reset value of jc_s_q from being treated as a real sample.
    if (vld_q) begin
      legal_d = dec_legal;
      phase_d = dec_phase;
      if (dec_legal) begin
        idx_d  = dec_idx;
        seed_d = 1'b1;
      end
      // Until a legal sample has seeded idx there is no predecessor to compare.
      if (seed_q) begin
        case (state_q)
          SEARCH: begin
            if (is_succ) run_d = run_q + 1'b1;
            else if (!is_hold) run_d = '0;
            if (run_d == RUN_W'(LOCK_CNT)) begin
              state_d = LOCKED;
              run_d   = '0;
              hold_d  = '0;
            end
          end
          default: begin
            if (is_succ) hold_d = '0;
            else if (is_hold) begin
              hold_d = hold_q + 1'b1;
              stall  = (hold_d == HOLD_W'(STALL_MAX + 1));
            end
            if (!(is_succ || is_hold) || stall) begin
              step_err_d = 1'b1;
              if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
              state_d = SEARCH;
              run_d   = '0;
              hold_d  = '0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      jc_s_q     <= '0;
      vld_q      <= 1'b0;
      seed_q     <= 1'b0;
      state_q    <= SEARCH;
      run_q      <= '0;
      hold_q     <= '0;
      phase_q    <= '0;
      idx_q      <= '0;
      legal_q    <= 1'b0;
      step_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      jc_s_q     <= jc_s_d;
      vld_q      <= vld_d;
      seed_q     <= seed_d;
      state_q    <= state_d;
      run_q      <= run_d;
      hold_q     <= hold_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      legal_q    <= legal_d;
      step_err_q <= step_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign phase    = phase_q;
  assign idx      = idx_q;
  assign legal    = legal_q;
  assign locked   = (state_q == LOCKED);
  assign step_err = step_err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// tb/tb_johnson_phase_decoder.sv - scoreboard bench for johnson_phase_decoder
module tb_johnson_phase_decoder;

  logic       clk = 1'b0;
  logic       r;
  logic [3:0] jc;
  logic [7:0] phase;
  logic [2:0] idx;
  logic       legal, locked, step_err;
  logic [7:0] err_cnt;

  johnson_phase_decoder dut (
    .clk      (clk),
    .r        (r),
    .jc       (jc),
    .phase    (phase),
    .idx      (idx),
    .legal    (legal),
    .locked   (locked),
    .step_err (step_err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       legal;
    logic [2:0] idx;
    logic [7:0] phase;
    logic       locked;
    logic       step_err;
    logic [7:0] err_cnt;
  } exp_t;

  exp_t sbq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int m_idx, m_run, m_hold, m_err;
  bit m_seed, m_locked;
  int cur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic decode_ref(input logic [3:0] c, output int ni);
    case (c)
      4'b0000: ni = 0;
      4'b0001: ni = 1;
      4'b0011: ni = 2;
      4'b0111: ni = 3;
      4'b1111: ni = 4;
      4'b1110: ni = 5;
      4'b1100: ni = 6;
      4'b1000: ni = 7;
      default: ni = -1;
    endcase
    return (ni >= 0);
  endfunction

  function automatic logic [3:0] code_of(input int i);
    logic [3:0] t [8];
    t = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    return t[i % 8];
  endfunction

  task automatic model_reset();
    m_idx = 0; m_run = 0; m_hold = 0; m_err = 0;
    m_seed = 0; m_locked = 0;
    sbq.delete();
  endtask

  task automatic model_push(input logic [3:0] c);
    exp_t e;
    int   ni;
    logic lg, succ, hld, err;
    lg = decode_ref(c, ni);
    succ = 0; hld = 0; err = 0;
    if (m_seed) begin
      succ = lg && (ni == (m_idx + 1) % 8);
      hld  = lg && (ni == m_idx);
      if (!m_locked) begin
        if (succ) m_run++;
        else if (!hld) m_run = 0;
        if (m_run == 4) begin m_locked = 1; m_run = 0; m_hold = 0; end
      end else begin
        if (succ) m_hold = 0;
        else if (hld) begin m_hold++; if (m_hold == 16) err = 1; end
        else err = 1;
        if (err) begin
          if (m_err < 255) m_err++;
          m_locked = 0; m_run = 0; m_hold = 0;
        end
      end
    end
    if (lg) begin m_idx = ni; m_seed = 1; end
    e.legal    = lg;
    e.idx      = 3'(m_idx);
    e.phase    = lg ? 8'(1 << ni) : 8'h00;
    e.locked   = m_locked;
    e.step_err = err;
    e.err_cnt  = 8'(m_err);
    sbq.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    e = sbq.pop_front();
    chk("legal",    32'(legal),    32'(e.legal));
    chk("idx",      32'(idx),      32'(e.idx));
    chk("phase",    32'(phase),    32'(e.phase));
    chk("locked",   32'(locked),   32'(e.locked));
    chk("step_err", 32'(step_err), 32'(e.step_err));
    chk("err_cnt",  32'(err_cnt),  32'(e.err_cnt));
  endtask

  task automatic step(input logic [3:0] c);
    jc = c;
    model_push(c);
    @(posedge clk);
    #1;
    if (sbq.size() >= 2) compare_front();
  endtask

  task automatic step_idx(input int i);
    cur = i % 8;
    step(code_of(cur));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_legal"},    32'(legal),    32'h0);
    chk({tag, "_idx"},      32'(idx),      32'h0);
    chk({tag, "_phase"},    32'(phase),    32'h0);
    chk({tag, "_locked"},   32'(locked),   32'h0);
    chk({tag, "_step_err"}, 32'(step_err), 32'h0);
    chk({tag, "_err_cnt"},  32'(err_cnt),  32'h0);
  endtask

  initial begin
    r  = 1'b1;
    jc = 4'b0000;
    model_reset();
    #2;
    check_zero("reset");
    @(posedge clk);
    #1;
    r = 1'b0;

    // Initial lock: fourth successor lands on idx 4.
    for (int i = 0; i < 4; i++) step_idx(i);
    step_idx(4);
    chk("pre_lock_locked", 32'(locked), 32'h0);
    step_idx(5);
    chk("lock_idx",    32'(idx),    32'h4);
    chk("lock_phase",  32'(phase),  32'h10);
    chk("lock_locked", 32'(locked), 32'h1);

    // Through the 7 -> 0 wrap while locked.
    for (int i = 6; i <= 9; i++) step_idx(i);

    // Illegal sample while locked, then relock.
    step(4'b0101);
    for (int i = 2; i <= 5; i++) step_idx(i);
    chk("illegal_step_err", 32'(step_err), 32'h0);

    // Skip 2 -> 4 while locked.
    for (int i = 6; i <= 10; i++) step_idx(i);
    step_idx(4);

    // Relock and stall on 0011.
    for (int i = 5; i <= 10; i++) step_idx(i);
    for (int k = 0; k < 16; k++) step_idx(2);

    // Drive the error counter into saturation and one beyond.
    while (m_err < 255) begin
      for (int k = 1; k <= 4; k++) step_idx(cur + 1);
      step_idx(cur + 2);
    end
    for (int k = 1; k <= 4; k++) step_idx(cur + 1);
    step_idx(cur + 2);
    chk("sat_model", 32'(m_err), 32'd255);

    // Relock, then asynchronous reset between edges.
    for (int k = 1; k <= 4; k++) step_idx(cur + 1);
    step_idx(cur + 1);
    chk("pre_reset_locked", 32'(locked), 32'h1);
    #2;
    r = 1'b1;
    #1;
    check_zero("midreset");
    r = 1'b0;
    model_reset();
    for (int i = 5; i <= 8; i++) step_idx(i);
    step_idx(9);
    chk("fresh_unlocked", 32'(locked), 32'h0);
    step_idx(10);
    step_idx(11);

    @(posedge clk);
    #1;
    if (sbq.size() >= 1) compare_front();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
